frame_scheduler: RTL



---
 rtl/frame_scheduler.sv | 116 +++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: frame strobe -> painter start/done -> optional game tick -> runner ack.
// Tracks dropped (overrun) frames and aborts a hung painter via a watchdog; all outputs registered.
`timescale 1ns/1ps
module frame_scheduler #(
  parameter int SLOW_DIV    = 2,
  parameter int WDOG_CYCLES = 1000000,
  parameter int OVR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             slow,
  input  logic             jump_in,
  input  logic             duck_in,
  output logic             paint_start,
  input  logic             paint_done,
  output logic             tick,
  output logic             tick_jump,
  output logic             tick_duck,
  input  logic             tick_ack,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic             timeout_err,
  output logic [15:0]      frame_cnt
);

  localparam int DIV_W  = $clog2(SLOW_DIV);
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SLOW_DIV - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PAINT, TICK, WAIT_ACK} state_t;

  state_t              state;
  logic                jump_pend;
  logic                duck_pend;
  logic [DIV_W-1:0]    div_cnt;
  logic [WDOG_W-1:0]   wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      paint_start <= 1'b0;
      tick        <= 1'b0;
      tick_jump   <= 1'b0;
      tick_duck   <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      jump_pend   <= 1'b0;
      duck_pend   <= 1'b0;
      div_cnt     <= '0;
      wdog        <= '0;
    end else begin
      paint_start <= 1'b0;
      tick        <= 1'b0;
      if (jump_in) jump_pend <= 1'b1;
      if (duck_in) duck_pend <= 1'b1;
      if (!slow) div_cnt <= '0;

      // Any strobe outside IDLE is a dropped frame, including the cycle we leave WAIT_ACK.
      if (frame_start && state != IDLE && overrun_cnt != {OVR_W{1'b1}})
        overrun_cnt <= overrun_cnt + OVR_W'(1);

      case (state)
        IDLE: begin
          wdog <= '0;
          if (frame_start) begin
            state       <= PAINT;
            busy        <= 1'b1;
            paint_start <= 1'b1;
          end
        end
        PAINT: begin
          wdog <= wdog + WDOG_W'(1);
          // wdog==0 marks the first PAINT cycle, where paint_done is still the previous frame's level.
          if (wdog != '0 && paint_done) begin
            if (slow && div_cnt != DIV_LAST) begin
              div_cnt <= div_cnt + DIV_W'(1);
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              if (slow) div_cnt <= '0;
              state     <= TICK;
              tick      <= 1'b1;
              tick_jump <= jump_pend;
              tick_duck <= duck_pend;
              jump_pend <= jump_in;
              duck_pend <= duck_in;
            end
          end else if (wdog == WDOG_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        TICK: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tick_ack) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
